// File: rtl/modulo_controle_ataque_pkg.sv
// Shared definitions for the attack controller: FSM states, 7-seg status codes,
// board dimensions and cell/bit helpers.
package modulo_controle_ataque_pkg;

    localparam int N_ROWS  = 7;
    localparam int N_COLS  = 5;
    localparam int N_CELLS = N_ROWS * N_COLS;

    localparam logic [2:0] LAST_ROW = 3'(N_ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(N_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POS  = 3'd1,
        S_ATQ  = 3'd2,
        S_VIEW = 3'd3,
        S_RES  = 3'd4,
        S_FIM  = 3'd5
    } state_t;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_POS  = 4'd1;
    localparam logic [3:0] ST_ATQ  = 4'd2;
    localparam logic [3:0] ST_VIEW = 4'd3;
    localparam logic [3:0] ST_WIN  = 4'd4;
    localparam logic [3:0] ST_LOSE = 4'd5;

    // Row 0 / column 0 sits at the MSB of the 35-bit maps.
    function automatic logic [5:0] cell_idx(input logic [2:0] lin, input logic [2:0] col);
        cell_idx = 6'd34 - (({3'b000, lin} * 6'd5) + {3'b000, col});
    endfunction

    function automatic logic [5:0] popcount_map(input logic [N_CELLS-1:0] map);
        logic [5:0] acc;
        acc = 6'd0;
        for (int i = 0; i < N_CELLS; i++) begin
            acc = acc + {5'b00000, map[i]};
        end
        return acc;
    endfunction

    function automatic state_t mode_state(input logic [1:0] hh);
        case (hh)
            2'b00:   mode_state = S_IDLE;
            2'b01:   mode_state = S_POS;
            2'b10:   mode_state = S_ATQ;
            2'b11:   mode_state = S_VIEW;
            default: mode_state = S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/modulo_debounce_botao.sv
// Button conditioner: 2-flop synchronizer, optional stability filter
// (CONTROLE_ATAQUE_DEBOUNCE_EN) and rising-edge detector producing a press pulse.
module modulo_debounce_botao #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic press
);

    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic prev_r;

    // Two-stage synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

`ifdef CONTROLE_ATAQUE_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic          stable_r;

    // Accept a new level only after it has differed from the accepted one for DEB_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (sync2_r == stable_r) begin
            cnt_r    <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r    <= '0;
            stable_r <= sync2_r;
        end else begin
            cnt_r    <= cnt_r + CW'(1);
        end
    end

    assign level_s = stable_r;
`else
    assign level_s = sync2_r;
`endif

    // Previous level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!clr) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level_s;
        end
    end

    assign press = level_s & ~prev_r;

endmodule

// File: rtl/modulo_controle_ataque.sv
// Battleship attack controller: mode FSM, cursor, shot/hit bookkeeping.
// Optional button debounce is enabled with CONTROLE_ATAQUE_DEBOUNCE_EN.
module modulo_controle_ataque
    import modulo_controle_ataque_pkg::*;
#(
    parameter int N_SHOTS    = 15,
    parameter int DEB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [1:0]  hh1,
    input  logic        btn_conf,
    input  logic        btn_count,
    input  logic [34:0] po_map,
    input  logic [34:0] at_map,
    output logic        po_load,
    output logic        at_clr,
    output logic        at_we,
    output logic [2:0]  cur_lin,
    output logic [2:0]  cur_col,
    output logic        res_hit,
    output logic        res_miss,
    output logic [3:0]  shots_left,
    output logic [5:0]  hits,
    output logic        game_over,
    output logic        win,
    output logic [3:0]  status
);

    localparam logic [3:0] SHOTS_INIT = 4'(N_SHOTS);

    state_t      state_r;
    state_t      state_n;
    state_t      mode_s;
    logic        conf_s;
    logic        count_s;
    logic [5:0]  cell_s;
    logic        hit_s;
    logic [2:0]  adv_lin_s;
    logic [2:0]  adv_col_s;
    logic [5:0]  ship_cells_r;
    logic [5:0]  ship_n;
    logic [2:0]  lin_n;
    logic [2:0]  col_n;
    logic [3:0]  shots_n;
    logic [5:0]  hits_n;
    logic        win_n;
    logic        over_n;
    logic        po_load_n;
    logic        at_clr_n;
    logic        at_we_n;
    logic        hit_n;
    logic        miss_n;
    logic [3:0]  status_n;

    modulo_debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_conf (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn_conf),
        .press (conf_s)
    );

    modulo_debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_count (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn_count),
        .press (count_s)
    );

    assign mode_s = mode_state(hh1);
    assign cell_s = cell_idx(cur_lin, cur_col);
    assign hit_s  = po_map[cell_s];

    // Row-major cursor advance with wrap at the last column and last cell.
    always_comb begin
        adv_lin_s = cur_lin;
        adv_col_s = cur_col + 3'd1;
        if (cur_col == LAST_COL) begin
            adv_col_s = 3'd0;
            if (cur_lin == LAST_ROW) begin
                adv_lin_s = 3'd0;
            end else begin
                adv_lin_s = cur_lin + 3'd1;
            end
        end else begin
            adv_col_s = cur_col + 3'd1;
        end
    end

    // Next state, next counters and next strobes.
    always_comb begin
        state_n   = state_r;
        lin_n     = cur_lin;
        col_n     = cur_col;
        shots_n   = shots_left;
        hits_n    = hits;
        ship_n    = ship_cells_r;
        win_n     = win;
        over_n    = game_over;
        po_load_n = 1'b0;
        at_clr_n  = 1'b0;
        at_we_n   = 1'b0;
        hit_n     = 1'b0;
        miss_n    = 1'b0;
        case (state_r)
            S_IDLE, S_VIEW: begin
                state_n = mode_s;
            end
            S_POS: begin
                if (mode_s != S_POS) begin
                    state_n = mode_s;
                end else if (conf_s) begin
                    po_load_n = 1'b1;
                    ship_n    = popcount_map(po_map);
                end else if (count_s) begin
                    lin_n = adv_lin_s;
                    col_n = adv_col_s;
                end else begin
                    state_n = S_POS;
                end
            end
            S_ATQ: begin
                if (mode_s != S_ATQ) begin
                    state_n = mode_s;
                end else if (conf_s) begin
                    // A confirm on an attacked cell or with no ships loaded is dropped, count included.
                    if (!at_map[cell_s] && (ship_cells_r != 6'd0)) begin
                        at_we_n = 1'b1;
                        shots_n = shots_left - 4'd1;
                        state_n = S_RES;
                    end else begin
                        state_n = S_ATQ;
                    end
                end else if (count_s) begin
                    lin_n = adv_lin_s;
                    col_n = adv_col_s;
                end else begin
                    state_n = S_ATQ;
                end
            end
            S_RES: begin
                if (hit_s) begin
                    hit_n  = 1'b1;
                    hits_n = hits + 6'd1;
                end else begin
                    miss_n = 1'b1;
                end
                if (hits_n == ship_cells_r) begin
                    state_n = S_FIM;
                    win_n   = 1'b1;
                    over_n  = 1'b1;
                end else if (shots_left == 4'd0) begin
                    state_n = S_FIM;
                    over_n  = 1'b1;
                end else begin
                    state_n = S_ATQ;
                end
            end
            S_FIM: begin
                if (hh1 == 2'b00) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_FIM;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if ((state_n == S_IDLE) && (state_r != S_IDLE)) begin
            at_clr_n = 1'b1;
            shots_n  = SHOTS_INIT;
            hits_n   = 6'd0;
            win_n    = 1'b0;
            over_n   = 1'b0;
            lin_n    = 3'd0;
            col_n    = 3'd0;
        end else begin
            at_clr_n = 1'b0;
        end
    end

    // 7-seg status code derived from the state being entered.
    always_comb begin
        case (state_n)
            S_IDLE:  status_n = ST_IDLE;
            S_POS:   status_n = ST_POS;
            S_ATQ:   status_n = ST_ATQ;
            S_RES:   status_n = ST_ATQ;
            S_VIEW:  status_n = ST_VIEW;
            S_FIM:   status_n = win_n ? ST_WIN : ST_LOSE;
            default: status_n = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any result pending in S_RES.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r      <= S_IDLE;
            cur_lin      <= 3'd0;
            cur_col      <= 3'd0;
            shots_left   <= SHOTS_INIT;
            hits         <= 6'd0;
            ship_cells_r <= 6'd0;
            win          <= 1'b0;
            game_over    <= 1'b0;
            po_load      <= 1'b0;
            at_clr       <= 1'b0;
            at_we        <= 1'b0;
            res_hit      <= 1'b0;
            res_miss     <= 1'b0;
            status       <= ST_IDLE;
        end else begin
            state_r      <= state_n;
            cur_lin      <= lin_n;
            cur_col      <= col_n;
            shots_left   <= shots_n;
            hits         <= hits_n;
            ship_cells_r <= ship_n;
            win          <= win_n;
            game_over    <= over_n;
            po_load      <= po_load_n;
            at_clr       <= at_clr_n;
            at_we        <= at_we_n;
            res_hit      <= hit_n;
            res_miss     <= miss_n;
            status       <= status_n;
        end
    end

endmodule
